fifo_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the async FIFO (`fifo`) between NUM_REQ producers in the write clock domain.
- Grants one requester at a time for a burst of up to BURST_LEN words, then moves to the next requester.
- Drives the FIFO `write_en`/`data_in` and honours `mem_full` in the same cycle, so no word is lost or duplicated.
- Sits directly in front of `fifo`; the read side is untouched.

---
 rtl/fifo_write_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ write-domain producers.
// Each grant covers a burst of up to BURST_LEN words; mem_full stalls the burst in the same cycle.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          write_clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          mem_full,
    output logic                          write_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          grant_valid,
    output logic [IDW-1:0]                grant_id
);

    localparam int             BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0]  LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [IDW-1:0] LAST_REQ  = IDW'(NUM_REQ - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] w_rr_ptr_nxt;
    logic [IDW-1:0] r_grant_id;
    logic [IDW-1:0] w_grant_id_nxt;
    logic [BW-1:0]  r_beat_cnt;
    logic [BW-1:0]  w_beat_cnt_nxt;
    logic           r_grant_valid;
    logic [IDW-1:0] w_pick;
    logic           w_pick_ok;
    logic [IDW-1:0] w_next_id;
    logic           w_req_g;
    logic           w_ack_g;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_pick    = '0;
        w_pick_ok = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                w_pick    = IDW'(idx);
                w_pick_ok = 1'b1;
            end
        end
    end

    assign w_next_id = (r_grant_id == LAST_REQ) ? '0 : r_grant_id + 1'b1;
    assign w_req_g   = req[r_grant_id];
    assign w_ack_g   = (r_state == S_BURST) & w_req_g & ~mem_full;

    always_comb begin
        ack = '0;
        if (w_ack_g) begin
            ack[r_grant_id] = 1'b1;
        end
    end

    assign write_en    = w_ack_g;
    assign data_in     = r_grant_valid ? req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_grant_id_nxt = r_grant_id;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pick_ok) begin
                    w_state_nxt    = S_BURST;
                    w_grant_id_nxt = w_pick;
                    w_beat_cnt_nxt = '0;
                end
            end
            S_BURST: begin
                if (w_ack_g) begin
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_state_nxt  = S_IDLE;
                        w_rr_ptr_nxt = w_next_id;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end else if (!w_req_g) begin
                    // Requester withdrew: end the burst early and move on.
                    w_state_nxt  = S_IDLE;
                    w_rr_ptr_nxt = w_next_id;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge write_clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_beat_cnt    <= '0;
            r_grant_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_beat_cnt    <= w_beat_cnt_nxt;
            r_grant_valid <= (w_state_nxt == S_BURST);
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: producer queues, a FIFO occupancy model and a grant-rule reference model.
// Directed scenarios first, then randomized traffic against a small FIFO.
module tb_fifo_write_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int BL    = 4;
    localparam int IDW   = 2;
    localparam int DEPTH = 6;

    logic              write_clk = 1'b0;
    logic              reset     = 1'b1;
    logic [N-1:0]      req       = '0;
    logic [N*DW-1:0]   req_data  = '0;
    logic [N-1:0]      ack;
    logic              mem_full  = 1'b0;
    logic              write_en;
    logic [DW-1:0]     data_in;
    logic              grant_valid;
    logic [IDW-1:0]    grant_id;

    always #5 write_clk = ~write_clk;

    fifo_write_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .BURST_LEN (BL),
        .IDW       (IDW)
    ) dut (
        .write_clk  (write_clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .mem_full   (mem_full),
        .write_en   (write_en),
        .data_in    (data_in),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] src_q [N][$];
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    bit  force_full = 1'b0;
    bit  rd_en      = 1'b1;
    int  fifo_depth = DEPTH;
    int  n_pushed   = 0;
    int  dut_writes = 0;

    // Reference: is a grant open, who holds it, words taken so far, where the next scan starts.
    bit m_burst;
    int m_gid;
    int m_cnt;
    int m_ptr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_burst = 1'b0;
        m_gid   = 0;
        m_cnt   = 0;
        m_ptr   = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i] = (src_q[i].size() != 0);
            req_data[i*DW +: DW] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
        end
        mem_full = force_full || (fifo_q.size() >= fifo_depth);
    endtask

    task automatic load(input int r, input int cnt, input bit rnd, input logic [DW-1:0] base);
        for (int k = 0; k < cnt; k++) begin
            src_q[r].push_back(rnd ? DW'($urandom_range(1, 255)) : DW'(base + DW'(k) * 8'h11));
            n_pushed++;
        end
    endtask

    task automatic step();
        logic [N-1:0]  e_ack;
        logic [DW-1:0] e_data;
        logic          s_we;
        logic [DW-1:0] s_data;
        int            gid_was;
        @(negedge write_clk);
        e_ack = '0;
        if (m_burst && req[m_gid] && !mem_full) e_ack[m_gid] = 1'b1;
        e_data = m_burst ? req_data[m_gid*DW +: DW] : '0;
        check("ack", 32'(ack), 32'(e_ack));
        check("write_en", 32'(write_en), 32'(|e_ack));
        check("data_in", 32'(data_in), 32'(e_data));
        check("grant_valid", 32'(grant_valid), 32'(m_burst));
        check("grant_id", 32'(grant_id), 32'(m_gid));
        s_we    = write_en;
        s_data  = data_in;
        gid_was = m_gid;
        @(posedge write_clk);
        if (!m_burst) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (req[(m_ptr + k) % N]) begin
                    m_gid   = (m_ptr + k) % N;
                    m_burst = 1'b1;
                end
            end
            m_cnt = 0;
        end else if (e_ack != '0) begin
            if (m_cnt == BL - 1) begin
                m_burst = 1'b0;
                m_ptr   = (m_gid + 1) % N;
            end else begin
                m_cnt++;
            end
        end else if (!req[m_gid]) begin
            m_burst = 1'b0;
            m_ptr   = (m_gid + 1) % N;
        end
        if (e_ack != '0) void'(src_q[gid_was].pop_front());
        if (s_we === 1'b1) begin
            fifo_q.push_back(s_data);
            dut_writes++;
        end
        if (rd_en && fifo_q.size() > 0 && $urandom_range(0, 1) == 1) void'(fifo_q.pop_front());
        #1 drive();
    endtask

    function automatic bit busy();
        bit b;
        b = m_burst;
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input string tag, input int budget);
        int c;
        c = 0;
        while (busy() && c < budget) begin
            step();
            c++;
        end
        check({tag, "_timeout"}, 32'(c < budget), 32'd1);
    endtask

    task automatic check_fifo(input string tag);
        check({tag, "_count"}, 32'(fifo_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < fifo_q.size(); k++) begin
            check({tag, "_word"}, 32'(fifo_q[k]), 32'(exp_q[k]));
        end
        fifo_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int c;
        model_reset();

        // Reset held with every requester asserting.
        for (int i = 0; i < N; i++) load(i, 2, 1'b1, 8'h00);
        #2 reset = 1'b0;
        drive();
        #5;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_write_en", 32'(write_en), 32'd0);
        check("rst_data_in", 32'(data_in), 32'd0);
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        @(posedge write_clk);
        #2 reset = 1'b1;
        drain("init", 200);

        // Single requester 2 with three words, then withdraws.
        fifo_q.delete();
        rd_en = 1'b0;
        fifo_depth = 1000;
        load(2, 3, 1'b0, 8'h11);
        exp_q = '{8'h11, 8'h22, 8'h33};
        drive();
        drain("single", 50);
        check_fifo("single_seq");

        // rr_ptr now 3: requester 3 must win over requester 0.
        load(0, 1, 1'b0, 8'hA0);
        load(3, 1, 1'b0, 8'hB0);
        exp_q = '{8'hB0, 8'hA0};
        drive();
        drain("rr_wrap", 50);
        check_fifo("rr_wrap_seq");

        // All four continuously requesting.
        rd_en = 1'b1;
        for (int i = 0; i < N; i++) load(i, 8, 1'b1, 8'h00);
        drive();
        drain("all4", 300);
        fifo_q.delete();

        // Requester 1 stalled by mem_full after its second word.
        rd_en = 1'b0;
        load(1, 4, 1'b0, 8'h11);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        drive();
        c = 0;
        while (fifo_q.size() < 2 && c < 50) begin
            step();
            c++;
        end
        check("full_setup_timeout", 32'(c < 50), 32'd1);
        force_full = 1'b1;
        drive();
        repeat (5) step();
        force_full = 1'b0;
        drive();
        drain("full", 50);
        check_fifo("full_seq");

        // Reset pulsed during requester 3's third beat.
        load(3, 4, 1'b0, 8'h11);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        drive();
        c = 0;
        while (!(m_burst && m_gid == 3 && m_cnt == 2) && c < 50) begin
            step();
            c++;
        end
        check("midrst_setup_timeout", 32'(c < 50), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("midrst_write_en", 32'(write_en), 32'd0);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_grant_valid", 32'(grant_valid), 32'd0);
        model_reset();
        @(posedge write_clk);
        #1 reset = 1'b1;
        drain("midrst", 50);
        check_fifo("midrst_seq");

        // Two producers feeding the FIFO; read order must be preserved.
        load(0, 4, 1'b0, 8'h11);
        load(1, 4, 1'b0, 8'h55);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        drive();
        drain("integ", 100);
        check_fifo("integ_seq");

        // Randomized traffic against a shallow FIFO with random reads.
        rd_en = 1'b1;
        fifo_depth = 3;
        for (int t = 0; t < 400; t++) begin
            int r;
            r = $urandom_range(0, N - 1);
            if ($urandom_range(0, 2) == 0 && src_q[r].size() < 3) load(r, 1, 1'b1, 8'h00);
            force_full = ($urandom_range(0, 9) == 0);
            drive();
            step();
        end
        force_full = 1'b0;
        drive();
        drain("random", 500);
        check("total_writes", 32'(dut_writes), 32'(n_pushed));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
